reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 The block SHALL have parameter NUM_ENTRIES, default 4, giving the number of station entries (2..8).
REQ-002 The block SHALL have parameter TAG_BASE, default 1, giving the tag of entry 0; entry i owns tag TAG_BASE+i, and TAG_BASE SHALL be nonzero.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the operand width.
REQ-004 The block SHALL have parameter TAG_W, default 5, giving the tag width; tag 0 means "operand value valid, no producer".
REQ-005 The block SHALL have these ports:
- clk  in  1  clock; the block uses one clock.
- rst  in  1  reset; synchronous and active-high.
- in_issue_valid  in  1  issue request.
- in_opcode  in  6  operation code.
- in_val_1, in_val_2  in  DATA_W  operand values from the register status stage.
- in_tag_1, in_tag_2  in  TAG_W  operand producer tags; 0 means the value is valid.
- out_issue_ready  out  1  at least one entry is free.
- out_issue_tag  out  TAG_W  tag assigned to the instruction being issued, fed to register-status in_bank_tag.
- in_CDB_broadcast  in  1  CDB result valid.
- in_CDB_tag  in  TAG_W  CDB producer tag.
- in_CDB_val  in  DATA_W  CDB result.
- in_fu_ready  in  1  functional unit can accept an operation this cycle.
- out_dispatch_valid  out  1  dispatch pulse, registered.
- out_dispatch_opcode  out  6  registered.
- out_dispatch_val_1, out_dispatch_val_2  out  DATA_W  registered.
- out_dispatch_tag  out  TAG_W  tag of the dispatched entry, registered.

Function
REQ-006 Each entry SHALL hold busy, opcode, val_1, tag_1, val_2 and tag_2.
REQ-007 out_issue_ready SHALL be combinational and high iff any entry is not busy in the current registered state.
REQ-008 out_issue_tag SHALL be combinational and equal TAG_BASE plus the index of the lowest-index free entry; it is don't-care when the station is full.
REQ-009 An issue SHALL be accepted at a clock edge iff in_issue_valid and out_issue_ready are both high; the lowest free entry then becomes busy and captures the opcode, values and tags.
REQ-010 When the station is full, in_issue_valid SHALL be ignored and no state SHALL change from it.
REQ-011 Issue-time CDB bypass: if in_CDB_broadcast is high and in_CDB_tag equals a nonzero in_tag_k in the same cycle, the entry SHALL store val_k=in_CDB_val and tag_k=0.
REQ-012 CDB snoop: on every edge where in_CDB_broadcast is high, every busy entry with tag_k equal to in_CDB_tag and nonzero SHALL set val_k=in_CDB_val and tag_k=0; both operands of one entry may be captured in the same cycle.
REQ-013 A CDB tag of 0 SHALL never match anything.
REQ-014 An entry SHALL be ready when it is busy and tag_1==0 and tag_2==0, evaluated on registered state, so a value captured from the CDB at edge N makes the entry eligible at edge N+1.
REQ-015 Dispatch: at each edge where in_fu_ready is high and at least one entry is ready, the lowest-index ready entry SHALL be copied to the out_dispatch_* registers, out_dispatch_valid SHALL be set to 1 and that entry's busy SHALL be cleared.
REQ-016 On every other edge out_dispatch_valid SHALL be 0 and the out_dispatch_* data registers SHALL hold their previous values.
REQ-017 Minimum latency SHALL be: issue with both tags 0 accepted at edge N gives out_dispatch_valid high after edge N+1.
REQ-018 An entry freed by dispatch at edge N SHALL NOT be reallocated at edge N, and SHALL be allocatable from edge N+1.
REQ-019 Issue, CDB snoop and dispatch occurring at the same edge SHALL act on disjoint entries with no lost update.
REQ-020 A CDB broadcast SHALL NOT alter the entry dispatched at that same edge.

Reset
REQ-021 While rst is high at an edge, all entries SHALL become not busy, all stored tags and values SHALL become 0, out_dispatch_valid SHALL become 0 and all out_dispatch_* data SHALL become 0.
REQ-022 Reset SHALL override issue, snoop and dispatch in the same cycle.
REQ-023 After reset, out_issue_ready SHALL be 1 and out_issue_tag SHALL equal TAG_BASE.
REQ-024 A reset asserted mid-operation SHALL discard all pending entries.

Verification
REQ-025 Ready issue: issue opcode 3 with val_1=5, tag_1=0, val_2=7, tag_2=0, fu_ready=1 -> out_issue_tag=1; one cycle later dispatch_valid=1, val_1=5, val_2=7, dispatch_tag=1.
REQ-026 Wait on CDB: issue with tag_1=2, val_2=9, tag_2=0; CDB tag=2, val=7 two cycles later -> dispatch exactly one cycle after the broadcast with val_1=7, val_2=9.
REQ-027 Issue-time bypass: issue with tag_1=3 while CDB broadcasts tag=3, val=11 in the same cycle -> entry ready, dispatch next cycle with val_1=11.
REQ-028 Full and back-pressure: fu_ready=0 with 4 non-ready issues -> issue_ready=0 and a fifth issue is ignored; resolve entry 2 via CDB, raise fu_ready -> tag 3 dispatched; issue_ready rises the cycle after.
REQ-029 Simultaneous and reset: dispatch of entry 0 while a new issue occurs -> new instruction gets tag 2, not 1; assert rst with 3 busy entries -> next cycle issue_ready=1, issue_tag=1, dispatch_valid=0.

Source files
------------

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - Tomasulo-style reservation station with CDB snoop/bypass
// Lowest-free-entry allocation, lowest-ready-entry dispatch into registered outputs.
module reservation_station #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_BASE    = 1,
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_issue_valid,
  input  logic [5:0]        in_opcode,
  input  logic [DATA_W-1:0] in_val_1,
  input  logic [DATA_W-1:0] in_val_2,
  input  logic [TAG_W-1:0]  in_tag_1,
  input  logic [TAG_W-1:0]  in_tag_2,
  output logic              out_issue_ready,
  output logic [TAG_W-1:0]  out_issue_tag,
  input  logic              in_CDB_broadcast,
  input  logic [TAG_W-1:0]  in_CDB_tag,
  input  logic [DATA_W-1:0] in_CDB_val,
  input  logic              in_fu_ready,
  output logic              out_dispatch_valid,
  output logic [5:0]        out_dispatch_opcode,
  output logic [DATA_W-1:0] out_dispatch_val_1,
  output logic [DATA_W-1:0] out_dispatch_val_2,
  output logic [TAG_W-1:0]  out_dispatch_tag
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [NUM_ENTRIES-1:0] busy_q, busy_d;
  logic [5:0]             opcode_q [NUM_ENTRIES];
  logic [5:0]             opcode_d [NUM_ENTRIES];
  logic [DATA_W-1:0]      val1_q   [NUM_ENTRIES];
  logic [DATA_W-1:0]      val1_d   [NUM_ENTRIES];
  logic [DATA_W-1:0]      val2_q   [NUM_ENTRIES];
  logic [DATA_W-1:0]      val2_d   [NUM_ENTRIES];
  logic [TAG_W-1:0]       tag1_q   [NUM_ENTRIES];
  logic [TAG_W-1:0]       tag1_d   [NUM_ENTRIES];
  logic [TAG_W-1:0]       tag2_q   [NUM_ENTRIES];
  logic [TAG_W-1:0]       tag2_d   [NUM_ENTRIES];

  logic              disp_valid_q, disp_valid_d;
  logic [5:0]        disp_opcode_q, disp_opcode_d;
  logic [DATA_W-1:0] disp_val1_q, disp_val1_d;
  logic [DATA_W-1:0] disp_val2_q, disp_val2_d;
  logic [TAG_W-1:0]  disp_tag_q, disp_tag_d;

  logic [NUM_ENTRIES-1:0] ready;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       disp_idx;
  logic                   issue_fire;
  logic                   disp_fire;
  logic                   cdb_live;

  // Selection works purely on registered state, so issue and dispatch never pick the same entry.
  always_comb begin
    free_idx = '0;
    disp_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      ready[i] = busy_q[i] && (tag1_q[i] == '0) && (tag2_q[i] == '0);
      if (!busy_q[i]) free_idx = IDX_W'(i);
      if (ready[i])   disp_idx = IDX_W'(i);
    end
  end

  assign out_issue_ready = ~&busy_q;
  assign out_issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
  assign issue_fire      = in_issue_valid && out_issue_ready;
  assign disp_fire       = in_fu_ready && (|ready);
  assign cdb_live        = in_CDB_broadcast && (in_CDB_tag != '0);

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      opcode_d[i] = opcode_q[i];
      val1_d[i]   = val1_q[i];
      val2_d[i]   = val2_q[i];
      tag1_d[i]   = tag1_q[i];
      tag2_d[i]   = tag2_q[i];
      if (busy_q[i] && cdb_live) begin
        if (tag1_q[i] == in_CDB_tag) begin
          val1_d[i] = in_CDB_val;
          tag1_d[i] = '0;
        end
        if (tag2_q[i] == in_CDB_tag) begin
          val2_d[i] = in_CDB_val;
          tag2_d[i] = '0;
        end
      end
    end

    if (disp_fire) busy_d[disp_idx] = 1'b0;

    if (issue_fire) begin
      busy_d[free_idx]   = 1'b1;
      opcode_d[free_idx] = in_opcode;
      val1_d[free_idx]   = in_val_1;
      tag1_d[free_idx]   = in_tag_1;
      val2_d[free_idx]   = in_val_2;
      tag2_d[free_idx]   = in_tag_2;
      if (cdb_live && (in_tag_1 == in_CDB_tag)) begin
        val1_d[free_idx] = in_CDB_val;
        tag1_d[free_idx] = '0;
      end
      if (cdb_live && (in_tag_2 == in_CDB_tag)) begin
        val2_d[free_idx] = in_CDB_val;
        tag2_d[free_idx] = '0;
      end
    end
  end

  always_comb begin
    disp_valid_d  = disp_fire;
    disp_opcode_d = disp_opcode_q;
    disp_val1_d   = disp_val1_q;
    disp_val2_d   = disp_val2_q;
    disp_tag_d    = disp_tag_q;
    if (disp_fire) begin
      disp_opcode_d = opcode_q[disp_idx];
      disp_val1_d   = val1_q[disp_idx];
      disp_val2_d   = val2_q[disp_idx];
      disp_tag_d    = TAG_W'(TAG_BASE) + TAG_W'(disp_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q        <= '0;
      disp_valid_q  <= 1'b0;
      disp_opcode_q <= '0;
      disp_val1_q   <= '0;
      disp_val2_q   <= '0;
      disp_tag_q    <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        opcode_q[i] <= '0;
        val1_q[i]   <= '0;
        val2_q[i]   <= '0;
        tag1_q[i]   <= '0;
        tag2_q[i]   <= '0;
      end
    end else begin
      busy_q        <= busy_d;
      disp_valid_q  <= disp_valid_d;
      disp_opcode_q <= disp_opcode_d;
      disp_val1_q   <= disp_val1_d;
      disp_val2_q   <= disp_val2_d;
      disp_tag_q    <= disp_tag_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        opcode_q[i] <= opcode_d[i];
        val1_q[i]   <= val1_d[i];
        val2_q[i]   <= val2_d[i];
        tag1_q[i]   <= tag1_d[i];
        tag2_q[i]   <= tag2_d[i];
      end
    end
  end

  assign out_dispatch_valid  = disp_valid_q;
  assign out_dispatch_opcode = disp_opcode_q;
  assign out_dispatch_val_1  = disp_val1_q;
  assign out_dispatch_val_2  = disp_val2_q;
  assign out_dispatch_tag    = disp_tag_q;

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed self-checking bench for reservation_station
module tb_reservation_station;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_issue_valid;
  logic [5:0]  in_opcode;
  logic [31:0] in_val_1, in_val_2;
  logic [4:0]  in_tag_1, in_tag_2;
  logic        out_issue_ready;
  logic [4:0]  out_issue_tag;
  logic        in_CDB_broadcast;
  logic [4:0]  in_CDB_tag;
  logic [31:0] in_CDB_val;
  logic        in_fu_ready;
  logic        out_dispatch_valid;
  logic [5:0]  out_dispatch_opcode;
  logic [31:0] out_dispatch_val_1, out_dispatch_val_2;
  logic [4:0]  out_dispatch_tag;

  int total = 0;
  int bad = 0;

  reservation_station dut (
    .clk(clk), .rst(rst),
    .in_issue_valid(in_issue_valid), .in_opcode(in_opcode),
    .in_val_1(in_val_1), .in_val_2(in_val_2),
    .in_tag_1(in_tag_1), .in_tag_2(in_tag_2),
    .out_issue_ready(out_issue_ready), .out_issue_tag(out_issue_tag),
    .in_CDB_broadcast(in_CDB_broadcast), .in_CDB_tag(in_CDB_tag), .in_CDB_val(in_CDB_val),
    .in_fu_ready(in_fu_ready),
    .out_dispatch_valid(out_dispatch_valid), .out_dispatch_opcode(out_dispatch_opcode),
    .out_dispatch_val_1(out_dispatch_val_1), .out_dispatch_val_2(out_dispatch_val_2),
    .out_dispatch_tag(out_dispatch_tag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [5:0] op, input logic [31:0] v1, input logic [4:0] t1,
                             input logic [31:0] v2, input logic [4:0] t2);
    in_issue_valid = 1'b1;
    in_opcode = op;
    in_val_1 = v1; in_tag_1 = t1;
    in_val_2 = v2; in_tag_2 = t2;
  endtask

  task automatic drive_cdb(input logic [4:0] t, input logic [31:0] v);
    in_CDB_broadcast = 1'b1;
    in_CDB_tag = t;
    in_CDB_val = v;
  endtask

  task automatic idle();
    in_issue_valid = 1'b0;
    in_CDB_broadcast = 1'b0;
    in_CDB_tag = '0;
    in_CDB_val = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    in_fu_ready = 1'b0;
    in_opcode = '0; in_val_1 = '0; in_val_2 = '0; in_tag_1 = '0; in_tag_2 = '0;
    do_reset();
    total++; if (out_issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %0d want 1", out_issue_ready); end
    total++; if (out_issue_tag !== 5'd1) begin bad++; $display("FAIL reset_tag got %0d want 1", out_issue_tag); end
    total++; if (out_dispatch_valid !== 1'b0) begin bad++; $display("FAIL reset_dvalid got %0d want 0", out_dispatch_valid); end
    total++; if (out_dispatch_val_1 !== 32'd0) begin bad++; $display("FAIL reset_dval1 got %0d want 0", out_dispatch_val_1); end
    total++; if (out_dispatch_tag !== 5'd0) begin bad++; $display("FAIL reset_dtag got %0d want 0", out_dispatch_tag); end
  endtask

  task automatic test_ready_issue();
    in_fu_ready = 1'b1;
    drive_issue(6'd3, 32'd5, 5'd0, 32'd7, 5'd0);
    total++; if (out_issue_tag !== 5'd1) begin bad++; $display("FAIL ready_issue_tag got %0d want 1", out_issue_tag); end
    tick();
    idle();
    total++; if (out_dispatch_valid !== 1'b0) begin bad++; $display("FAIL ready_early_valid got %0d want 0", out_dispatch_valid); end
    tick();
    total++; if (out_dispatch_valid !== 1'b1) begin bad++; $display("FAIL ready_valid got %0d want 1", out_dispatch_valid); end
    total++; if (out_dispatch_opcode !== 6'd3) begin bad++; $display("FAIL ready_opcode got %0d want 3", out_dispatch_opcode); end
    total++; if (out_dispatch_val_1 !== 32'd5) begin bad++; $display("FAIL ready_val1 got %0d want 5", out_dispatch_val_1); end
    total++; if (out_dispatch_val_2 !== 32'd7) begin bad++; $display("FAIL ready_val2 got %0d want 7", out_dispatch_val_2); end
    total++; if (out_dispatch_tag !== 5'd1) begin bad++; $display("FAIL ready_dtag got %0d want 1", out_dispatch_tag); end
    tick();
    total++; if (out_dispatch_valid !== 1'b0) begin bad++; $display("FAIL ready_pulse got %0d want 0", out_dispatch_valid); end
    total++; if (out_dispatch_val_1 !== 32'd5) begin bad++; $display("FAIL ready_hold got %0d want 5", out_dispatch_val_1); end
  endtask

  task automatic test_wait_cdb();
    in_fu_ready = 1'b1;
    drive_issue(6'd4, 32'hDEAD, 5'd2, 32'd9, 5'd0);
    tick();
    idle();
    tick();
    total++; if (out_dispatch_valid !== 1'b0) begin bad++; $display("FAIL wait_no_disp got %0d want 0", out_dispatch_valid); end
    drive_cdb(5'd2, 32'd7);
    tick();
    idle();
    total++; if (out_dispatch_valid !== 1'b0) begin bad++; $display("FAIL wait_same_edge got %0d want 0", out_dispatch_valid); end
    tick();
    total++; if (out_dispatch_valid !== 1'b1) begin bad++; $display("FAIL wait_valid got %0d want 1", out_dispatch_valid); end
    total++; if (out_dispatch_val_1 !== 32'd7) begin bad++; $display("FAIL wait_val1 got %0d want 7", out_dispatch_val_1); end
    total++; if (out_dispatch_val_2 !== 32'd9) begin bad++; $display("FAIL wait_val2 got %0d want 9", out_dispatch_val_2); end
    tick();
  endtask

  task automatic test_bypass();
    in_fu_ready = 1'b1;
    drive_issue(6'd5, 32'd0, 5'd3, 32'd4, 5'd0);
    drive_cdb(5'd3, 32'd11);
    tick();
    idle();
    tick();
    total++; if (out_dispatch_valid !== 1'b1) begin bad++; $display("FAIL bypass_valid got %0d want 1", out_dispatch_valid); end
    total++; if (out_dispatch_val_1 !== 32'd11) begin bad++; $display("FAIL bypass_val1 got %0d want 11", out_dispatch_val_1); end
    total++; if (out_dispatch_val_2 !== 32'd4) begin bad++; $display("FAIL bypass_val2 got %0d want 4", out_dispatch_val_2); end
    tick();
  endtask

  task automatic test_full();
    logic [4:0] exp_tag;
    in_fu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_tag = 5'(i + 1);
      drive_issue(6'(i + 1), 32'd0, 5'(9 + i), 32'(100 + i), 5'd0);
      total++; if (out_issue_tag !== exp_tag) begin bad++; $display("FAIL full_tag%0d got %0d want %0d", i, out_issue_tag, exp_tag); end
      tick();
    end
    idle();
    total++; if (out_issue_ready !== 1'b0) begin bad++; $display("FAIL full_ready got %0d want 0", out_issue_ready); end
    drive_issue(6'd9, 32'd1, 5'd0, 32'd2, 5'd0);
    tick();
    idle();
    total++; if (out_issue_ready !== 1'b0) begin bad++; $display("FAIL full_fifth got %0d want 0", out_issue_ready); end
    in_fu_ready = 1'b1;
    drive_cdb(5'd11, 32'd55);
    tick();
    idle();
    total++; if (out_dispatch_valid !== 1'b0) begin bad++; $display("FAIL full_early got %0d want 0", out_dispatch_valid); end
    total++; if (out_issue_ready !== 1'b0) begin bad++; $display("FAIL full_still got %0d want 0", out_issue_ready); end
    tick();
    total++; if (out_dispatch_valid !== 1'b1) begin bad++; $display("FAIL full_dvalid got %0d want 1", out_dispatch_valid); end
    total++; if (out_dispatch_tag !== 5'd3) begin bad++; $display("FAIL full_dtag got %0d want 3", out_dispatch_tag); end
    total++; if (out_dispatch_opcode !== 6'd3) begin bad++; $display("FAIL full_dop got %0d want 3", out_dispatch_opcode); end
    total++; if (out_dispatch_val_1 !== 32'd55) begin bad++; $display("FAIL full_dval1 got %0d want 55", out_dispatch_val_1); end
    total++; if (out_dispatch_val_2 !== 32'd102) begin bad++; $display("FAIL full_dval2 got %0d want 102", out_dispatch_val_2); end
    total++; if (out_issue_ready !== 1'b1) begin bad++; $display("FAIL full_rise got %0d want 1", out_issue_ready); end
    total++; if (out_issue_tag !== 5'd3) begin bad++; $display("FAIL full_free_tag got %0d want 3", out_issue_tag); end
    tick();
    total++; if (out_dispatch_valid !== 1'b0) begin bad++; $display("FAIL full_after got %0d want 0", out_dispatch_valid); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    in_fu_ready = 1'b1;
    drive_issue(6'd1, 32'd21, 5'd0, 32'd22, 5'd0);
    tick();
    drive_issue(6'd2, 32'd0, 5'd20, 32'd33, 5'd0);
    total++; if (out_issue_tag !== 5'd2) begin bad++; $display("FAIL sim_tag got %0d want 2", out_issue_tag); end
    tick();
    idle();
    total++; if (out_dispatch_valid !== 1'b1) begin bad++; $display("FAIL sim_dvalid got %0d want 1", out_dispatch_valid); end
    total++; if (out_dispatch_tag !== 5'd1) begin bad++; $display("FAIL sim_dtag got %0d want 1", out_dispatch_tag); end
    total++; if (out_issue_tag !== 5'd1) begin bad++; $display("FAIL sim_realloc got %0d want 1", out_issue_tag); end
    drive_cdb(5'd20, 32'd44);
    tick();
    idle();
    total++; if (out_dispatch_valid !== 1'b0) begin bad++; $display("FAIL sim_gap got %0d want 0", out_dispatch_valid); end
    tick();
    total++; if (out_dispatch_tag !== 5'd2) begin bad++; $display("FAIL sim_dtag2 got %0d want 2", out_dispatch_tag); end
    total++; if (out_dispatch_val_1 !== 32'd44) begin bad++; $display("FAIL sim_dval1 got %0d want 44", out_dispatch_val_1); end
    total++; if (out_dispatch_val_2 !== 32'd33) begin bad++; $display("FAIL sim_dval2 got %0d want 33", out_dispatch_val_2); end
    tick();
  endtask

  task automatic test_reset_mid();
    in_fu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_issue(6'd7, 32'd0, 5'd9, 32'd1, 5'd0);
      tick();
    end
    total++; if (out_issue_tag !== 5'd4) begin bad++; $display("FAIL mid_tag got %0d want 4", out_issue_tag); end
    drive_issue(6'd8, 32'd1, 5'd0, 32'd1, 5'd0);
    in_fu_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    total++; if (out_issue_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got %0d want 1", out_issue_ready); end
    total++; if (out_issue_tag !== 5'd1) begin bad++; $display("FAIL mid_itag got %0d want 1", out_issue_tag); end
    total++; if (out_dispatch_valid !== 1'b0) begin bad++; $display("FAIL mid_dvalid got %0d want 0", out_dispatch_valid); end
    drive_cdb(5'd9, 32'd66);
    tick();
    idle();
    tick();
    total++; if (out_dispatch_valid !== 1'b0) begin bad++; $display("FAIL mid_discard got %0d want 0", out_dispatch_valid); end
    total++; if (out_dispatch_tag !== 5'd0) begin bad++; $display("FAIL mid_dtag got %0d want 0", out_dispatch_tag); end
  endtask

  initial begin
    test_reset();
    test_ready_issue();
    test_wait_cdb();
    test_bypass();
    test_full();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
